// File: rtl/uart_tx_arb.sv
// uart_tx_arb
// Round-robin arbiter that lets one of PORTS AXI-Stream byte sources own a
// single uart_tx transmitter for a whole packet (or at most MAX_BEATS beats).
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   s_axis_tdata    : PORTS*DATA_WIDTH requester data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid   : per-requester valid
//   s_axis_tlast    : per-requester end-of-packet marker
//   s_axis_tready   : per-requester ready (only the granted port can be high)
//   m_axis_tdata    : byte to uart_tx
//   m_axis_tvalid   : valid to uart_tx
//   m_axis_tready   : ready from uart_tx
//   grant_valid     : a requester currently owns the transmitter
//   grant_idx       : owning requester (meaningful only with grant_valid)
//   pkt_done        : one-cycle pulse after a grant is released
//   pkt_cut         : one-cycle pulse when the release was forced by MAX_BEATS
module uart_tx_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int PORTS      = 4,
    parameter int MAX_BEATS  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        grant_valid,
    output logic [2:0]                  grant_idx,
    output logic                        pkt_done,
    output logic                        pkt_cut
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0] state_q,     state_d;
    logic [2:0] grant_idx_q, grant_idx_d;
    logic [2:0] last_idx_q,  last_idx_d;
    logic [7:0] beat_cnt_q,  beat_cnt_d;
    logic       pkt_done_q,  pkt_done_d;
    logic       pkt_cut_q,   pkt_cut_d;

    // Signals of the currently granted port, selected by comparison rather
    // than by variable bit-select so any PORTS value maps cleanly onto the
    // fixed 3-bit index.
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  sel_valid;
    logic                  sel_last;

    // Round-robin pick for the next grant.
    logic       pick_found;
    logic [2:0] pick_idx;

    logic       beat;
    logic [7:0] beat_cnt_inc;

    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_idx_q == 3'(p)) begin
                sel_data  = s_axis_tdata[p*DATA_WIDTH +: DATA_WIDTH];
                sel_valid = s_axis_tvalid[p];
                sel_last  = s_axis_tlast[p];
            end
        end
    end

    // Search starts one past the previous owner and wraps, so the port that
    // just finished has the lowest priority for the next grant.
    always_comb begin
        int cand;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < PORTS; k++) begin
            cand = (int'(last_idx_q) + 1 + k) % PORTS;
            for (int p = 0; p < PORTS; p++) begin
                if (!pick_found && p == cand && s_axis_tvalid[p]) begin
                    pick_found = 1'b1;
                    pick_idx   = 3'(p);
                end
            end
        end
    end

    assign grant_valid   = (state_q == ST_GRANT);
    assign grant_idx     = grant_idx_q;
    assign m_axis_tvalid = grant_valid && sel_valid;
    assign m_axis_tdata  = grant_valid ? sel_data : '0;
    assign pkt_done      = pkt_done_q;
    assign pkt_cut       = pkt_cut_q;

    // Ready is a combinational pass-through of the transmitter's ready, gated
    // by state so an asynchronous reset drops it without waiting for an edge.
    generate
        for (genvar gi = 0; gi < PORTS; gi++) begin : g_ready
            assign s_axis_tready[gi] = grant_valid && (grant_idx_q == 3'(gi)) && m_axis_tready;
        end
    endgenerate

    assign beat         = m_axis_tvalid && m_axis_tready;
    assign beat_cnt_inc = beat_cnt_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        last_idx_d  = last_idx_q;
        beat_cnt_d  = beat_cnt_q;
        pkt_done_d  = 1'b0;
        pkt_cut_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d     = ST_GRANT;
                    grant_idx_d = pick_idx;
                end
            end
            default: begin
                if (beat) begin
                    beat_cnt_d = beat_cnt_inc;
                    // tlast wins over the beat limit: a packet that ends
                    // exactly at MAX_BEATS is a normal release, not a cut.
                    if (sel_last || beat_cnt_inc == 8'(MAX_BEATS)) begin
                        state_d    = ST_IDLE;
                        last_idx_d = grant_idx_q;
                        beat_cnt_d = '0;
                        pkt_done_d = 1'b1;
                        pkt_cut_d  = !sel_last;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            grant_idx_q <= '0;
            last_idx_q  <= 3'(PORTS - 1);
            beat_cnt_q  <= '0;
            pkt_done_q  <= 1'b0;
            pkt_cut_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            last_idx_q  <= last_idx_d;
            beat_cnt_q  <= beat_cnt_d;
            pkt_done_q  <= pkt_done_d;
            pkt_cut_q   <= pkt_cut_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb
// Directed bench for uart_tx_arb (DATA_WIDTH=8, PORTS=4, MAX_BEATS=4).
// Inputs change on the falling edge; outputs are compared 1 time unit later,
// i.e. well away from the rising edge where state updates.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tvalid;
    logic [3:0]  s_axis_tlast;
    logic [3:0]  s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        grant_valid;
    logic [2:0]  grant_idx;
    logic        pkt_done;
    logic        pkt_cut;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_arb #(.DATA_WIDTH(8), .PORTS(4), .MAX_BEATS(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .grant_valid   (grant_valid),
        .grant_idx     (grant_idx),
        .pkt_done      (pkt_done),
        .pkt_cut       (pkt_cut)
    );

    typedef struct {
        logic [3:0]  tv;
        logic [3:0]  tl;
        logic [31:0] td;
        logic        mr;
        logic        gv;
        logic [2:0]  gi;
        logic        mv;
        logic [7:0]  md;
        logic [3:0]  rdy;
        logic        done;
        logic        cut;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [3:0] tv, input logic [3:0] tl, input logic [31:0] td,
                       input logic mr, input logic gv, input logic [2:0] gi, input logic mv,
                       input logic [7:0] md, input logic [3:0] rdy, input logic done,
                       input logic cut);
        vec_t v;
        v.tv = tv; v.tl = tl; v.td = td; v.mr = mr;
        v.gv = gv; v.gi = gi; v.mv = mv; v.md = md;
        v.rdy = rdy; v.done = done; v.cut = cut;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] tv, input logic [3:0] tl, input logic [31:0] td,
                         input logic mr);
        s_axis_tvalid = tv;
        s_axis_tlast  = tl;
        s_axis_tdata  = td;
        m_axis_tready = mr;
    endtask

    task automatic do_reset();
        drive(4'h0, 4'h0, 32'h0, 1'b1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(4'h0, 4'h0, 32'h0, 1'b1);
        rst = 1'b1;
        #1;

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        check("rst_gv",   32'(grant_valid),   32'h0);
        check("rst_gi",   32'(grant_idx),     32'h0);
        check("rst_rdy",  32'(s_axis_tready), 32'h0);
        check("rst_mv",   32'(m_axis_tvalid), 32'h0);
        check("rst_done", 32'(pkt_done),      32'h0);
        check("rst_cut",  32'(pkt_cut),       32'h0);

        // ---------------- table ----------------
        //   tv     tl     td            mr    gv    gi    mv    md     rdy    done  cut
        // contention: all four ports with 1-byte packets -> 0,1,2,3
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 3'd0, 1'b1, 8'h11, 4'h1, 1'b0, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 3'd1, 1'b1, 8'h22, 4'h2, 1'b0, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 3'd2, 1'b1, 8'h33, 4'h4, 1'b0, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'hF, 4'hF, 32'h44332211, 1'b1, 1'b1, 3'd3, 1'b1, 8'h44, 4'h8, 1'b0, 1'b0);
        // wrap: last owner 3, ports 0 and 3 request -> 0
        add(4'h9, 4'h9, 32'h44332211, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'h9, 4'h9, 32'h44332211, 1'b1, 1'b1, 3'd0, 1'b1, 8'h11, 4'h1, 1'b0, 1'b0);
        // hog: port 1 streams without tlast, port 3 waits; cut after 4 beats
        add(4'hA, 4'h0, 32'h4400B100, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'hA, 4'h0, 32'h4400B100, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB1, 4'h2, 1'b0, 1'b0);
        add(4'hA, 4'h0, 32'h4400B200, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB2, 4'h2, 1'b0, 1'b0);
        add(4'hA, 4'h0, 32'h4400B300, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB3, 4'h2, 1'b0, 1'b0);
        add(4'hA, 4'h0, 32'h4400B400, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB4, 4'h2, 1'b0, 1'b0);
        add(4'hA, 4'h0, 32'h4400B500, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b1);
        add(4'hA, 4'h8, 32'h4400B500, 1'b1, 1'b1, 3'd3, 1'b1, 8'h44, 4'h8, 1'b0, 1'b0);
        add(4'h2, 4'h0, 32'h0000B500, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'h2, 4'h0, 32'h0000B500, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB5, 4'h2, 1'b0, 1'b0);
        // tvalid drop keeps the grant; short backpressure blocks ready
        add(4'h0, 4'h0, 32'h00000000, 1'b1, 1'b1, 3'd1, 1'b0, 8'h00, 4'h2, 1'b0, 1'b0);
        add(4'h2, 4'h0, 32'h0000B600, 1'b0, 1'b1, 3'd1, 1'b1, 8'hB6, 4'h0, 1'b0, 1'b0);
        add(4'h2, 4'h2, 32'h0000B600, 1'b1, 1'b1, 3'd1, 1'b1, 8'hB6, 4'h2, 1'b0, 1'b0);
        add(4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        // tlast on the MAX_BEATS beat is a normal release
        add(4'h4, 4'h0, 32'h00C10000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);
        add(4'h4, 4'h0, 32'h00C10000, 1'b1, 1'b1, 3'd2, 1'b1, 8'hC1, 4'h4, 1'b0, 1'b0);
        add(4'h4, 4'h0, 32'h00C20000, 1'b1, 1'b1, 3'd2, 1'b1, 8'hC2, 4'h4, 1'b0, 1'b0);
        add(4'h4, 4'h0, 32'h00C30000, 1'b1, 1'b1, 3'd2, 1'b1, 8'hC3, 4'h4, 1'b0, 1'b0);
        add(4'h4, 4'h4, 32'h00C40000, 1'b1, 1'b1, 3'd2, 1'b1, 8'hC4, 4'h4, 1'b0, 1'b0);
        add(4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b1, 1'b0);
        add(4'h0, 4'h0, 32'h00000000, 1'b1, 1'b0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0);

        rst = 1'b0;
        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            drive(vq[i].tv, vq[i].tl, vq[i].td, vq[i].mr);
            #1;
            $display("vec %0d: tv=%h tl=%h td=%h mr=%b -> gv=%b gi=%0d mv=%b md=%h rdy=%h done=%b cut=%b",
                     i, vq[i].tv, vq[i].tl, vq[i].td, vq[i].mr, grant_valid, grant_idx,
                     m_axis_tvalid, m_axis_tdata, s_axis_tready, pkt_done, pkt_cut);
            check($sformatf("vec%0d_gv", i), 32'(grant_valid), 32'(vq[i].gv));
            if (vq[i].gv) check($sformatf("vec%0d_gi", i), 32'(grant_idx), 32'(vq[i].gi));
            check($sformatf("vec%0d_mv", i), 32'(m_axis_tvalid), 32'(vq[i].mv));
            if (vq[i].mv) check($sformatf("vec%0d_md", i), 32'(m_axis_tdata), 32'(vq[i].md));
            check($sformatf("vec%0d_rdy", i),  32'(s_axis_tready), 32'(vq[i].rdy));
            check($sformatf("vec%0d_done", i), 32'(pkt_done),      32'(vq[i].done));
            check($sformatf("vec%0d_cut", i),  32'(pkt_cut),       32'(vq[i].cut));
        end

        // ---------------- backpressure: 20 stalled cycles ----------------
        do_reset();
        @(negedge clk);
        drive(4'h1, 4'h0, 32'h000000D1, 1'b1);
        #1;
        check("bp_idle_gv", 32'(grant_valid), 32'h0);
        @(negedge clk);
        #1;
        check("bp_grant_gi", 32'(grant_idx), 32'h0);
        check("bp_beat1_rdy", 32'(s_axis_tready), 32'h1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(4'h1, 4'h0, 32'h000000D2, 1'b0);
            #1;
            $display("bp stall %0d: gv=%b rdy=%h mv=%b", i, grant_valid, s_axis_tready, m_axis_tvalid);
            check($sformatf("bp_stall%0d_gv", i),  32'(grant_valid),   32'h1);
            check($sformatf("bp_stall%0d_rdy", i), 32'(s_axis_tready), 32'h0);
        end
        // one beat was taken before the stall, so beats 2 and 3 keep the
        // grant and beat 4 cuts it
        for (int b = 2; b <= 4; b++) begin
            @(negedge clk);
            drive(4'h1, 4'h0, 32'(8'hD0 + b), 1'b1);
            #1;
            $display("bp beat %0d: gv=%b md=%h cut=%b", b, grant_valid, m_axis_tdata, pkt_cut);
            check($sformatf("bp_beat%0d_gv", b), 32'(grant_valid),  32'h1);
            check($sformatf("bp_beat%0d_md", b), 32'(m_axis_tdata), 32'(8'hD0 + b));
        end
        @(negedge clk);
        drive(4'h0, 4'h0, 32'h0, 1'b1);
        #1;
        check("bp_cut_gv",   32'(grant_valid), 32'h0);
        check("bp_cut_done", 32'(pkt_done),    32'h1);
        check("bp_cut_cut",  32'(pkt_cut),     32'h1);

        // ---------------- asynchronous reset mid-packet ----------------
        do_reset();
        @(negedge clk);
        drive(4'h4, 4'h0, 32'h00E10000, 1'b1);
        #1;
        check("ar_idle_gv", 32'(grant_valid), 32'h0);
        @(negedge clk);
        #1;
        check("ar_grant_gi", 32'(grant_idx), 32'h2);
        @(negedge clk);
        drive(4'h4, 4'h0, 32'h00E20000, 1'b1);
        @(negedge clk);
        drive(4'h4, 4'h0, 32'h00E30000, 1'b1);
        #1;
        check("ar_pre_gv",  32'(grant_valid),   32'h1);
        check("ar_pre_rdy", 32'(s_axis_tready), 32'h4);
        #1;
        rst = 1'b1;
        #1;
        $display("async rst: gv=%b rdy=%h mv=%b done=%b cut=%b",
                 grant_valid, s_axis_tready, m_axis_tvalid, pkt_done, pkt_cut);
        check("ar_gv",  32'(grant_valid),   32'h0);
        check("ar_rdy", 32'(s_axis_tready), 32'h0);
        check("ar_mv",  32'(m_axis_tvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h5, 4'h1, 32'h00E30055, 1'b1);
        #1;
        check("ar_rel_gv", 32'(grant_valid), 32'h0);
        @(negedge clk);
        #1;
        $display("after rst: gv=%b gi=%0d md=%h", grant_valid, grant_idx, m_axis_tdata);
        check("ar_first_gv", 32'(grant_valid),  32'h1);
        check("ar_first_gi", 32'(grant_idx),    32'h0);
        check("ar_first_md", 32'(m_axis_tdata), 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
